// File: rtl/gpu_load_sequencer.sv
// gpu_load_sequencer
//   Brings the GPU core out of reset once the clock wizard has held lock for
//   RST_CYCLES consecutive cycles, then on request streams NBYTES parameter
//   bytes from a small host-writable buffer to the GPU dedicated inputs,
//   aligned to the first vsync rising edge after the request.
//
// Ports
//   clk        GPU core clock (only clock of the block)
//   reset      asynchronous, active-high
//   locked     clock-wizard lock, already synchronous to clk
//   wr_en      host write strobe into the 16x8 parameter buffer
//   wr_addr    host write address
//   wr_data    host write data
//   start      single-cycle load request
//   vsync      GPU frame boundary, synchronous to clk
//   gpu_rst_n  active-low reset to the GPU core
//   ui_data    byte bus to the GPU
//   ui_strobe  one-cycle strobe marking a new byte on ui_data
//   busy       load in progress (waiting for vsync, sending, finishing)
//   done       one-cycle pulse when a load completes
//   pend       a start was latched while busy and has not been served yet
module gpu_load_sequencer #(
  parameter int NBYTES     = 16,
  parameter int RST_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       locked,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       start,
  input  logic       vsync,
  output logic       gpu_rst_n,
  output logic [7:0] ui_data,
  output logic       ui_strobe,
  output logic       busy,
  output logic       done,
  output logic       pend
);

  localparam logic [2:0] HOLD  = 3'd0;
  localparam logic [2:0] IDLE  = 3'd1;
  localparam logic [2:0] WAITV = 3'd2;
  localparam logic [2:0] SEND  = 3'd3;
  localparam logic [2:0] FIN   = 3'd4;

  localparam logic [3:0] LAST_IDX = 4'(NBYTES - 1);
  localparam logic [7:0] CNT_LAST = 8'(RST_CYCLES - 1);

  logic [2:0] state;
  logic [7:0] cnt;
  logic [3:0] idx;
  logic       phase;       // 0: strobe cycle of a byte, 1: hold cycle
  logic       vsync_prev;
  logic [7:0] param_buf [16];

  logic lock_lost;
  logic engaged;
  logic vsync_rise;

  assign lock_lost  = !locked && (state != HOLD);
  assign engaged    = (state == WAITV) || (state == SEND) || (state == FIN);
  assign vsync_rise = vsync && !vsync_prev;

  // Parameter buffer: never reset, writable in every state. A byte is read
  // on the edge that ends its strobe-cycle state, so a write landing later
  // than that edge only reaches the next load.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      param_buf[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vsync_prev <= 1'b0;
    end else begin
      vsync_prev <= vsync;
    end
  end

  // Control FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= HOLD;
      cnt   <= 8'd0;
      idx   <= 4'd0;
      phase <= 1'b0;
      pend  <= 1'b0;
    end else if (lock_lost) begin
      // Losing lock anywhere outside HOLD abandons everything, queued start too.
      state <= HOLD;
      cnt   <= 8'd0;
      idx   <= 4'd0;
      phase <= 1'b0;
      pend  <= 1'b0;
    end else begin
      case (state)
        HOLD: begin
          if (!locked) begin
            cnt <= 8'd0;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE;
            cnt   <= 8'd0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        IDLE: begin
          if (start || pend) begin
            state <= WAITV;
            pend  <= 1'b0;
          end
        end
        WAITV: begin
          // vsync already high on entry has vsync_prev=1 and cannot qualify.
          if (vsync_rise) begin
            state <= SEND;
            idx   <= 4'd0;
            phase <= 1'b0;
          end
        end
        SEND: begin
          if (phase) begin
            phase <= 1'b0;
            if (idx == LAST_IDX) begin
              state <= FIN;
            end else begin
              idx <= idx + 4'd1;
            end
          end else begin
            phase <= 1'b1;
          end
        end
        FIN: begin
          state <= IDLE;
          idx   <= 4'd0;
        end
        default: begin
          state <= HOLD;
          cnt   <= 8'd0;
          idx   <= 4'd0;
          phase <= 1'b0;
        end
      endcase

      // Single-deep request queue; repeated starts while pend=1 are absorbed.
      if (engaged && start) begin
        pend <= 1'b1;
      end
    end
  end

  // Registered outputs, derived from the state held during the cycle. A lock
  // loss clears them on the same edge the FSM drops to HOLD, which also
  // suppresses a done pulse that FIN would otherwise produce.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gpu_rst_n <= 1'b0;
      ui_data   <= 8'h00;
      ui_strobe <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (lock_lost) begin
      gpu_rst_n <= 1'b0;
      ui_data   <= 8'h00;
      ui_strobe <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      gpu_rst_n <= (state != HOLD);
      busy      <= engaged;
      done      <= (state == FIN);
      if (state == SEND) begin
        ui_strobe <= !phase;
        if (!phase) begin
          ui_data <= param_buf[idx];
        end
      end else begin
        ui_strobe <= 1'b0;
        ui_data   <= 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_gpu_load_sequencer.sv
// Directed bench for gpu_load_sequencer with NBYTES=4, RST_CYCLES=16.
module tb_gpu_load_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       locked;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       start;
  logic       vsync;
  logic       gpu_rst_n;
  logic [7:0] ui_data;
  logic       ui_strobe;
  logic       busy;
  logic       done;
  logic       pend;

  int n_tests = 0;
  int n_fail  = 0;

  gpu_load_sequencer #(.NBYTES(4), .RST_CYCLES(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .locked    (locked),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .start     (start),
    .vsync     (vsync),
    .gpu_rst_n (gpu_rst_n),
    .ui_data   (ui_data),
    .ui_strobe (ui_strobe),
    .busy      (busy),
    .done      (done),
    .pend      (pend)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  // Count edges from the current point until gpu_rst_n must rise: still low
  // after 16 edges, high after 17. Also flags any done pulse in the window.
  task automatic lock_rise(input string tag);
    logic seen_done;
    seen_done = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      tick();
      if (done) seen_done = 1'b1;
      if (k == 16) chk({tag, ".rst_n_at16"}, 32'(gpu_rst_n), 32'd0);
      if (k == 17) chk({tag, ".rst_n_at17"}, 32'(gpu_rst_n), 32'd1);
    end
    chk({tag, ".no_done"}, 32'(seen_done), 32'd0);
  endtask

  // Expects the FSM to be in WAITV by the next edge. Produces a vsync rise
  // sampled at edge t, then checks edges t+1..t+10. Starts can be injected
  // so they are sampled at edge t+k+1; do_wr writes addr3=5A then addr0=0F
  // on edges t+4 and t+5.
  task automatic load_seq(input string tag, input logic [31:0] bytes,
                          input int start_k1, input int start_k2, input bit do_wr);
    logic [7:0] ed;
    logic       es;
    logic       ep;
    vsync = 1'b0;
    tick();
    chk({tag, ".busy_waitv"}, 32'(busy), 32'd1);
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      es = (k % 2 == 1) && (k <= 7);
      ed = (k <= 8) ? bytes[8*((k-1)/2) +: 8] : 8'h00;
      ep = (start_k1 >= 0) && (k > start_k1) && (k <= 9);
      chk($sformatf("%s.strobe%0d", tag, k), 32'(ui_strobe), 32'(es));
      chk($sformatf("%s.data%0d", tag, k), 32'(ui_data), 32'(ed));
      chk($sformatf("%s.done%0d", tag, k), 32'(done), 32'(k == 9));
      chk($sformatf("%s.busy%0d", tag, k), 32'(busy), 32'(k <= 9));
      chk($sformatf("%s.pend%0d", tag, k), 32'(pend), 32'(ep));
      start = (k == start_k1) || (k == start_k2);
      if (do_wr) begin
        wr_en   = (k == 3) || (k == 4);
        wr_addr = (k == 3) ? 4'd3 : 4'd0;
        wr_data = (k == 3) ? 8'h5A : 8'h0F;
      end
    end
    start = 1'b0;
    wr_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; locked = 1'b1; wr_en = 1'b0; wr_addr = 4'd0; wr_data = 8'h00;
    start = 1'b0; vsync = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst.gpu_rst_n", 32'(gpu_rst_n), 32'd0);
    chk("rst.ui_data", 32'(ui_data), 32'h00);
    chk("rst.ui_strobe", 32'(ui_strobe), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.pend", 32'(pend), 32'd0);

    // Lock sequence with locked held high
    reset = 1'b0;
    lock_rise("lock1");

    // Lock drops at cycle 10 of the hold: count restarts on re-lock
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (10) tick();
    chk("lock2.still_held", 32'(gpu_rst_n), 32'd0);
    locked = 1'b0;
    tick();
    tick();
    locked = 1'b1;
    lock_rise("lock2");

    // Fill the buffer
    wr(4'd0, 8'hA1);
    wr(4'd1, 8'hB2);
    wr(4'd2, 8'hC3);
    wr(4'd3, 8'hD4);
    chk("idle.busy", 32'(busy), 32'd0);

    // Plain full load
    start = 1'b1;
    tick();
    start = 1'b0;
    load_seq("load1", 32'hD4C3B2A1, -1, -1, 1'b0);

    // Queued start during SEND, plus a dropped third start
    start = 1'b1;
    tick();
    start = 1'b0;
    load_seq("queueA", 32'hD4C3B2A1, 3, 5, 1'b0);
    load_seq("queueB", 32'hD4C3B2A1, -1, -1, 1'b0);
    vsync = 1'b0; tick(); vsync = 1'b1; tick(); vsync = 1'b0;
    tick();
    tick();
    chk("drop3.busy", 32'(busy), 32'd0);
    chk("drop3.strobe", 32'(ui_strobe), 32'd0);

    // vsync already high before start must not trigger a send
    vsync = 1'b1;
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("vhigh.strobe%0d", k), 32'(ui_strobe), 32'd0);
      chk($sformatf("vhigh.busy%0d", k), 32'(busy), 32'd1);
    end
    load_seq("vhigh", 32'hD4C3B2A1, -1, -1, 1'b0);

    // Writes during the byte-1 strobe: addr3 seen now, addr0 next load
    start = 1'b1;
    tick();
    start = 1'b0;
    load_seq("wrlate", 32'h5AC3B2A1, -1, -1, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    load_seq("wrnext", 32'h5AC3B20F, -1, -1, 1'b0);

    // Lock lost during byte 2 with a start queued
    start = 1'b1;
    tick();
    start = 1'b0;
    vsync = 1'b0;
    tick();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("lockdrop.strobe_b2", 32'(ui_strobe), 32'd1);
    chk("lockdrop.data_b2", 32'(ui_data), 32'hC3);
    chk("lockdrop.pend_before", 32'(pend), 32'd1);
    locked = 1'b0;
    tick();
    chk("lockdrop.gpu_rst_n", 32'(gpu_rst_n), 32'd0);
    chk("lockdrop.pend", 32'(pend), 32'd0);
    chk("lockdrop.busy", 32'(busy), 32'd0);
    chk("lockdrop.strobe", 32'(ui_strobe), 32'd0);
    chk("lockdrop.data", 32'(ui_data), 32'h00);
    chk("lockdrop.done", 32'(done), 32'd0);
    tick();
    locked = 1'b1;
    lock_rise("relock");
    vsync = 1'b1; tick(); vsync = 1'b0; tick(); vsync = 1'b1; tick(); vsync = 1'b0;
    tick();
    chk("relock.no_load", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of SEND
    start = 1'b1;
    tick();
    start = 1'b0;
    vsync = 1'b0;
    tick();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    repeat (3) tick();
    chk("arst.strobe_before", 32'(ui_strobe), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst.strobe", 32'(ui_strobe), 32'd0);
    chk("arst.data", 32'(ui_data), 32'h00);
    chk("arst.busy", 32'(busy), 32'd0);
    chk("arst.gpu_rst_n", 32'(gpu_rst_n), 32'd0);
    tick();
    tick();
    chk("arst.done", 32'(done), 32'd0);
    reset = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
